// File: rtl/spi_reg_bank.sv
// SPI mode-0 peripheral feeding a bank of NUM_REGS write-only registers over clk-domain sampling.
// Optional macro SPI_READBACK_EN: read frames shift the addressed register out on cipo.
module spi_reg_bank #(
    parameter int NUM_REGS = 5,
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 7
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sclk,
    input  logic                       copi,
    input  logic                       ncs,
    output logic                       cipo,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr
);
    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int CMD_W   = 1 + ADDR_W;
    localparam int CNT_W   = $clog2(FRAME_W + 2);
    localparam logic [CNT_W-1:0] CNT_CMD  = CNT_W'(CMD_W);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);
    localparam logic [ADDR_W:0]  ADDR_LIM = (ADDR_W + 1)'(NUM_REGS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [2:0]          sclk_sync_q;
    logic [1:0]          copi_sync_q;
    logic [2:0]          ncs_sync_q;
    logic [FRAME_W-1:0]  shift_q;
    logic [CNT_W-1:0]    bit_cnt_q;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic                wr_strobe_q, wr_strobe_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic                cipo_q, cipo_d;
    logic                cipo_oe_q, cipo_oe_d;

    logic                sclk_rise_s;
    logic                copi_s;
    logic                ncs_s;
    logic                ncs_rise_s;
    logic                ncs_fall_s;
    logic                frame_rw_s;
    logic [ADDR_W-1:0]   frame_addr_s;
    logic [DATA_W-1:0]   frame_data_s;
    logic                commit_s;

    // Two-flop synchronisers, with a third history flop on sclk/ncs for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= 3'b000;
            copi_sync_q <= 2'b00;
            ncs_sync_q  <= 3'b111;
        end else begin
            sclk_sync_q <= {sclk_sync_q[1:0], sclk};
            copi_sync_q <= {copi_sync_q[0], copi};
            ncs_sync_q  <= {ncs_sync_q[1:0], ncs};
        end
    end

    assign sclk_rise_s = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign copi_s      = copi_sync_q[1];
    assign ncs_s       = ncs_sync_q[1];
    assign ncs_rise_s  = ncs_sync_q[1] & ~ncs_sync_q[2];
    assign ncs_fall_s  = ~ncs_sync_q[1] & ncs_sync_q[2];

    // Frame shifter and saturating bit counter; a new selection restarts both
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q   <= {FRAME_W{1'b0}};
            bit_cnt_q <= {CNT_W{1'b0}};
        end else if (ncs_fall_s) begin
            shift_q   <= {FRAME_W{1'b0}};
            bit_cnt_q <= {CNT_W{1'b0}};
        end else if (sclk_rise_s && !ncs_s) begin
            shift_q <= {shift_q[FRAME_W-2:0], copi_s};
            if (bit_cnt_q != CNT_SAT) begin
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
        end
    end

    // First bit received lands in the MSB: R/W, then address, then data
    assign frame_rw_s   = shift_q[FRAME_W-1];
    assign frame_addr_s = shift_q[DATA_W +: ADDR_W];
    assign frame_data_s = shift_q[DATA_W-1:0];
    assign commit_s     = ncs_rise_s && (bit_cnt_q == CNT_FULL) && frame_rw_s
                          && ({1'b0, frame_addr_s} < ADDR_LIM);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; deselection returns to IDLE from any state
    always_comb begin
        state_d = state_q;
        if (ncs_rise_s) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ncs_fall_s ? ST_CMD : ST_IDLE;
                ST_CMD:  state_d = (bit_cnt_q == CNT_CMD) ? ST_DATA : ST_CMD;
                ST_DATA: state_d = (bit_cnt_q == CNT_FULL) ? ST_DONE : ST_DATA;
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

`ifdef SPI_READBACK_EN
    logic [DATA_W-1:0] out_shift_q, out_shift_d;
    logic [DATA_W-1:0] rd_data_s;
    logic              sclk_fall_s;
    logic              cmd_rw_s;
    logic [ADDR_W-1:0] cmd_addr_s;

    assign sclk_fall_s = ~sclk_sync_q[1] & sclk_sync_q[2];
    // After the command bits the R/W flag sits just above the address
    assign cmd_rw_s    = shift_q[ADDR_W];
    assign cmd_addr_s  = shift_q[ADDR_W-1:0];
`endif

    // Output logic: register file update, write strobe and serial readback
    always_comb begin
        wr_strobe_d = commit_s;
        wr_addr_d   = commit_s ? frame_addr_s : wr_addr_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (commit_s && (frame_addr_s == ADDR_W'(i))) begin
                regs_d[i] = frame_data_s;
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
`ifdef SPI_READBACK_EN
        rd_data_s = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            rd_data_s = (cmd_addr_s == ADDR_W'(i)) ? regs_q[i] : rd_data_s;
        end
        cipo_oe_d = ~ncs_s;
        if ((state_q == ST_CMD) && (state_d == ST_DATA)) begin
            out_shift_d = cmd_rw_s ? {DATA_W{1'b0}} : rd_data_s;
            cipo_d      = 1'b0;
        end else if ((state_d == ST_DATA) && sclk_fall_s) begin
            out_shift_d = out_shift_q << 1;
            cipo_d      = out_shift_q[DATA_W-1];
        end else if (state_d == ST_DATA) begin
            out_shift_d = out_shift_q;
            cipo_d      = cipo_q;
        end else begin
            out_shift_d = out_shift_q;
            cipo_d      = 1'b0;
        end
`else
        cipo_oe_d = 1'b0;
        cipo_d    = 1'b0;
`endif
    end

    // Register file and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= {ADDR_W{1'b0}};
            cipo_q      <= 1'b0;
            cipo_oe_q   <= 1'b0;
`ifdef SPI_READBACK_EN
            out_shift_q <= {DATA_W{1'b0}};
`endif
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            cipo_q      <= cipo_d;
            cipo_oe_q   <= cipo_oe_d;
`ifdef SPI_READBACK_EN
            out_shift_q <= out_shift_d;
`endif
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
    end

    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign cipo      = cipo_q;
    assign cipo_oe   = cipo_oe_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Scoreboard bench for spi_reg_bank: a default-size bank (a) and a 16x16 bank (b) share one SPI bus.
module tb_spi_reg_bank;
    localparam int NA = 5;
    localparam int WA = 8;
    localparam int NB = 16;
    localparam int WB = 16;
    localparam int AW = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, sclk, copi, ncs;
    logic cipo_a, cipo_oe_a, wr_strobe_a;
    logic cipo_b, cipo_oe_b, wr_strobe_b;
    logic [NA*WA-1:0] regs_a;
    logic [NB*WB-1:0] regs_b;
    logic [AW-1:0]    wr_addr_a, wr_addr_b;

    int n_checks = 0;
    int n_errors = 0;
    logic [38:0]   q_a[$];
    logic [38:0]   q_b[$];
    logic [WA-1:0] exp_a [NA];
    logic [WB-1:0] exp_b [NB];
    logic [31:0]   miso;
    logic          oe;

    spi_reg_bank u_dut_a (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
        .cipo(cipo_a), .cipo_oe(cipo_oe_a), .regs_flat(regs_a),
        .wr_strobe(wr_strobe_a), .wr_addr(wr_addr_a)
    );

    spi_reg_bank #(.NUM_REGS(NB), .DATA_W(WB), .ADDR_W(AW)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
        .cipo(cipo_b), .cipo_oe(cipo_oe_b), .regs_flat(regs_b),
        .wr_strobe(wr_strobe_b), .wr_addr(wr_addr_b)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] flat_a();
        logic [255:0] f;
        f = 256'd0;
        for (int i = 0; i < NA; i++) f[i*WA +: WA] = exp_a[i];
        return f;
    endfunction

    function automatic logic [255:0] flat_b();
        logic [255:0] f;
        f = 256'd0;
        for (int i = 0; i < NB; i++) f[i*WB +: WB] = exp_b[i];
        return f;
    endfunction

    task automatic push_a(input logic [6:0] addr, input logic [7:0] data);
        q_a.push_back({addr, 24'd0, data});
        exp_a[addr] = data;
    endtask

    task automatic push_b(input logic [6:0] addr, input logic [15:0] data);
        q_b.push_back({addr, 16'd0, data});
        exp_b[addr] = data;
    endtask

    task automatic clear_model();
        for (int i = 0; i < NA; i++) exp_a[i] = 8'h00;
        for (int i = 0; i < NB; i++) exp_b[i] = 16'h0000;
    endtask

    // Sends n bits of val MSB first; cipo of bank a is captured at each sclk rise.
    task automatic spi_frame(input logic [31:0] val, input int n, input int rst_at,
                             output logic [31:0] rx, output logic oe_seen);
        rx = 32'd0;
        oe_seen = 1'b0;
        ncs = 1'b0;
        repeat (8) @(posedge clk);
        for (int i = n - 1; i >= 0; i--) begin
            copi = val[i];
            repeat (8) @(posedge clk);
            sclk = 1'b1;
            rx = {rx[30:0], cipo_a};
            if (i == n - 1) oe_seen = cipo_oe_a;
            repeat (8) @(posedge clk);
            sclk = 1'b0;
            if (n - i == rst_at) begin
                rst_n = 1'b0;
                clear_model();
                repeat (3) @(posedge clk);
                rst_n = 1'b1;
            end
        end
        repeat (8) @(posedge clk);
        ncs = 1'b1;
        repeat (12) @(posedge clk);
    endtask

    task automatic end_frame(input string name);
        @(negedge clk);
        check({name, "_pending_a"}, 256'(q_a.size()), 256'd0);
        check({name, "_pending_b"}, 256'(q_b.size()), 256'd0);
        check({name, "_regs_a"}, 256'(regs_a), flat_a());
        check({name, "_regs_b"}, 256'(regs_b), flat_b());
    endtask

    // Monitor for bank a: every strobe must match the oldest expected write
    initial begin : mon_a
        logic [38:0] e;
        forever begin
            @(negedge clk);
            if (wr_strobe_a === 1'b1) begin
                if (q_a.size() == 0) begin
                    check("unexpected_strobe_a", 256'(wr_strobe_a), 256'd0);
                end else begin
                    e = q_a.pop_front();
                    check("wr_addr_a", 256'(wr_addr_a), 256'(e[38:32]));
                    check("wr_data_a", 256'(regs_a[e[38:32]*WA +: WA]), 256'(e[WA-1:0]));
                end
            end
        end
    end

    // Monitor for bank b
    initial begin : mon_b
        logic [38:0] e;
        forever begin
            @(negedge clk);
            if (wr_strobe_b === 1'b1) begin
                if (q_b.size() == 0) begin
                    check("unexpected_strobe_b", 256'(wr_strobe_b), 256'd0);
                end else begin
                    e = q_b.pop_front();
                    check("wr_addr_b", 256'(wr_addr_b), 256'(e[38:32]));
                    check("wr_data_b", 256'(regs_b[e[38:32]*WB +: WB]), 256'(e[WB-1:0]));
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        sclk  = 1'b0;
        copi  = 1'b0;
        ncs   = 1'b1;
        clear_model();
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_regs_a", 256'(regs_a), 256'd0);
        check("rst_regs_b", 256'(regs_b), 256'd0);
        check("rst_strobe_a", 256'(wr_strobe_a), 256'd0);
        check("rst_addr_a", 256'(wr_addr_a), 256'd0);
        check("rst_cipo_a", 256'(cipo_a), 256'd0);
        check("rst_oe_a", 256'(cipo_oe_a), 256'd0);
        check("rst_strobe_b", 256'(wr_strobe_b), 256'd0);
        @(posedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);

        push_a(7'd0, 8'hA5);
        spi_frame(32'h80A5, 16, -1, miso, oe);
        end_frame("wr_reg0");
        check("rx_on_write", 256'(miso[15:0]), 256'd0);

        spi_frame(32'h853C, 16, -1, miso, oe);
        end_frame("addr5_oob");

        spi_frame(32'h4108, 15, -1, miso, oe);
        end_frame("short15");

        spi_frame(32'h1827E, 17, -1, miso, oe);
        end_frame("long17");

        push_a(7'd2, 8'h5A);
        spi_frame(32'h825A, 16, -1, miso, oe);
        end_frame("wr_reg2");

        spi_frame(32'h0200, 16, -1, miso, oe);
        end_frame("rd_reg2");
`ifdef SPI_READBACK_EN
        check("rd_reg2_cipo", 256'(miso[15:0]), 256'h005A);
        check("rd_oe", 256'(oe), 256'd1);
`else
        check("rd_reg2_cipo", 256'(miso[15:0]), 256'd0);
        check("rd_oe", 256'(oe), 256'd0);
`endif

        spi_frame(32'h0900, 16, -1, miso, oe);
        end_frame("rd_addr9");
        check("rd_addr9_cipo", 256'(miso[15:0]), 256'd0);

        push_a(7'd4, 8'hC3);
        spi_frame(32'h84C3, 16, -1, miso, oe);
        end_frame("wr_reg4");

        spi_frame(32'h83FF, 16, 9, miso, oe);
        end_frame("rst_mid");

        push_a(7'd3, 8'h77);
        spi_frame(32'h8377, 16, -1, miso, oe);
        end_frame("wr_reg3");

        push_b(7'h0F, 16'hBEEF);
        spi_frame(32'h8FBEEF, 24, -1, miso, oe);
        end_frame("wide_reg15");
        check("wide_top", 256'(regs_b[255:240]), 256'hBEEF);

        spi_frame(32'h901234, 24, -1, miso, oe);
        end_frame("wide_oob");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
